// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared types and defaults for the raster timing generator.
//   - vga_state_e    : run/stop FSM states (IDLE, RUN, DRAIN)
//   - axis_timing_t  : active/front-porch/sync/back-porch for one axis
//   - vga_timing_t   : horizontal + vertical timing pair
//   - VGA_640X480_60 : standard 640x480@60 timing, used for parameter defaults
//   - axis_total()   : total period (in ticks or lines) of one axis
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vga_state_e;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{
    h: '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48},
    v: '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33}
  };

  function automatic int axis_total(input axis_timing_t t);
    return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// ---------------------------------------------------------------------------
// vga_axis_cnt
//   Generic wrap counter for one raster axis.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset (value -> RST_VAL)
//     load       : synchronous load of load_val (priority over inc)
//     load_val   : value taken on load
//     inc        : advance by one; at max the counter wraps to 0
//     max        : last value before wrap
//     value      : registered count
//     value_nxt  : value the counter takes at the next clk edge
//     wrap       : carry, 1 when inc is set while value==max
// ---------------------------------------------------------------------------
module vga_axis_cnt #(
  parameter int            CW      = 11,
  parameter logic [CW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          inc,
  input  logic [CW-1:0] max,
  output logic [CW-1:0] value,
  output logic [CW-1:0] value_nxt,
  output logic          wrap
);

  logic [CW-1:0] value_q, value_d;

  always_comb begin
    wrap    = inc && (value_q == max);
    value_d = value_q;
    if (load)      value_d = load_val;
    else if (wrap) value_d = '0;
    else if (inc)  value_d = value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= RST_VAL;
    else     value_q <= value_d;
  end

  assign value     = value_q;
  assign value_nxt = value_d;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised raster timing generator with run/stop FSM. A stop request
//   lets the current frame finish (DRAIN) before parking in IDLE at (0,0).
//   All outputs are registered and computed from the next x/y, so sync and
//   blank always describe the x/y shown in the same cycle.
//
//   Optional feature macro: VGA_TIMING_FETCH_EN
//     Adds fetch_x/fetch_y/fetch_valid: the raster position LEAD ticks ahead,
//     for a pixel pipeline that needs to fetch early.
//
//   Ports:
//     vgaclk       : pixel/system clock
//     reset        : asynchronous active-high reset
//     pix_en       : tick qualifier, nothing advances without it
//     run          : 1 = generate raster, 0 = stop at end of frame
//     hsync/vsync  : syncs at level HSYNC_POL/VSYNC_POL when asserted
//     sync_b       : composite sync, active-low
//     blank_b      : 1 inside the visible area while running
//     x, y         : current raster position
//     line_start   : one-cycle strobe when x becomes 0
//     frame_start  : one-cycle strobe when x and y become 0
//     frame_cnt    : completed frames, wraps at 255
//     active       : 1 in RUN or DRAIN
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   CW        = 11,
  parameter int   HACTIVE   = int'(VGA_640X480_60.h.active),
  parameter int   HFP       = int'(VGA_640X480_60.h.fp),
  parameter int   HSYN      = int'(VGA_640X480_60.h.sync),
  parameter int   HBP       = int'(VGA_640X480_60.h.bp),
  parameter int   VACTIVE   = int'(VGA_640X480_60.v.active),
  parameter int   VFP       = int'(VGA_640X480_60.v.fp),
  parameter int   VSYN      = int'(VGA_640X480_60.v.sync),
  parameter int   VBP       = int'(VGA_640X480_60.v.bp),
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   LEAD      = 2
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          run,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt,
`ifdef VGA_TIMING_FETCH_EN
  output logic [CW-1:0] fetch_x,
  output logic [CW-1:0] fetch_y,
  output logic          fetch_valid,
`endif
  output logic          active
);

  localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
  localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

  if ((HMAX - 1) >= (1 << CW) || (VMAX - 1) >= (1 << CW) || LEAD >= HMAX ||
      LEAD < 0 || HACTIVE < 1 || VACTIVE < 1 || HSYN < 1 || VSYN < 1) begin : g_bad_cfg
    $error("vga_timing_gen: timing parameters do not fit CW or LEAD >= HMAX");
  end

  localparam logic [CW-1:0] HLAST    = CW'(HMAX - 1);
  localparam logic [CW-1:0] VLAST    = CW'(VMAX - 1);
  localparam logic [CW-1:0] HVIS_END = CW'(HACTIVE - 1);
  localparam logic [CW-1:0] VVIS_END = CW'(VACTIVE - 1);
  localparam logic [CW-1:0] HS_BEG   = CW'(HACTIVE + HFP);
  localparam logic [CW-1:0] HS_END   = CW'(HACTIVE + HFP + HSYN - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(VACTIVE + VFP);
  localparam logic [CW-1:0] VS_END   = CW'(VACTIVE + VFP + VSYN - 1);

  vga_state_e state_q, state_d;

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          sync_b_q, sync_b_d;
  logic          blank_b_q, blank_b_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          active_q, active_d;

  logic          pos_inc, pos_load;
  logic          h_wrap, frame_wrap;
  logic [CW-1:0] x_val, x_nxt, y_val, y_nxt;

  // The raster only moves while running; IDLE pins it to the origin.
  assign pos_inc  = pix_en && (state_q != IDLE);
  assign pos_load = (state_q == IDLE);

  vga_axis_cnt #(.CW(CW), .RST_VAL('0)) u_hcnt (
    .clk      (vgaclk),
    .rst      (reset),
    .load     (pos_load),
    .load_val ('0),
    .inc      (pos_inc),
    .max      (HLAST),
    .value    (x_val),
    .value_nxt(x_nxt),
    .wrap     (h_wrap)
  );

  // V advances on the H carry; its own carry is the frame wrap.
  vga_axis_cnt #(.CW(CW), .RST_VAL('0)) u_vcnt (
    .clk      (vgaclk),
    .rst      (reset),
    .load     (pos_load),
    .load_val ('0),
    .inc      (h_wrap),
    .max      (VLAST),
    .value    (y_val),
    .value_nxt(y_nxt),
    .wrap     (frame_wrap)
  );

  // Next state. run is only looked at on ticks so that every output,
  // including active, holds between ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (pix_en && run) state_d = RUN;
      RUN:
        if (pix_en && !run) state_d = frame_wrap ? IDLE : DRAIN;
      DRAIN:
        if (pix_en) begin
          if (frame_wrap) state_d = IDLE;
          else if (run)   state_d = RUN;
        end
      default:
        state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next position and next state. A
  // transition into IDLE lands on (0,0) through the counter wrap, but
  // raises no strobes since the raster is no longer running.
  always_comb begin
    logic on_d, hs_act, vs_act;
    on_d          = (state_d != IDLE);
    hs_act        = on_d && (x_nxt >= HS_BEG) && (x_nxt <= HS_END);
    vs_act        = on_d && (y_nxt >= VS_BEG) && (y_nxt <= VS_END);
    hsync_d       = hs_act ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = vs_act ? VSYNC_POL : ~VSYNC_POL;
    sync_b_d      = ~(hs_act | vs_act);
    blank_b_d     = on_d && (x_nxt <= HVIS_END) && (y_nxt <= VVIS_END);
    line_start_d  = pix_en && on_d && (x_nxt == '0);
    frame_start_d = line_start_d && (y_nxt == '0);
    frame_cnt_d   = frame_cnt_q + {7'd0, frame_wrap};
    active_d      = on_d;
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      sync_b_q      <= 1'b1;
      blank_b_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      active_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      sync_b_q      <= sync_b_d;
      blank_b_q     <= blank_b_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      active_q      <= active_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign sync_b      = sync_b_q;
  assign blank_b     = blank_b_q;
  assign x           = x_val;
  assign y           = y_val;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;
  assign active      = active_q;

`ifdef VGA_TIMING_FETCH_EN
  // A second counter pair runs LEAD ticks ahead of the raster. It sits at
  // (LEAD,0) in IDLE, which is exactly LEAD ticks past the origin, so it
  // stays in lockstep with the raster without any subtraction.
  logic          fx_wrap, fy_wrap_unused;
  logic [CW-1:0] fx_val, fx_nxt, fy_val, fy_nxt;
  logic          fetch_valid_q, fetch_valid_d;

  vga_axis_cnt #(.CW(CW), .RST_VAL(CW'(LEAD))) u_fxcnt (
    .clk      (vgaclk),
    .rst      (reset),
    .load     (pos_load),
    .load_val (CW'(LEAD)),
    .inc      (pos_inc),
    .max      (HLAST),
    .value    (fx_val),
    .value_nxt(fx_nxt),
    .wrap     (fx_wrap)
  );

  vga_axis_cnt #(.CW(CW), .RST_VAL('0)) u_fycnt (
    .clk      (vgaclk),
    .rst      (reset),
    .load     (pos_load),
    .load_val ('0),
    .inc      (fx_wrap),
    .max      (VLAST),
    .value    (fy_val),
    .value_nxt(fy_nxt),
    .wrap     (fy_wrap_unused)
  );

  always_comb begin
    fetch_valid_d = (state_d != IDLE) && (fx_nxt <= HVIS_END) && (fy_nxt <= VVIS_END);
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) fetch_valid_q <= 1'b0;
    else       fetch_valid_q <= fetch_valid_d;
  end

  assign fetch_x     = fx_val;
  assign fetch_y     = fy_val;
  assign fetch_valid = fetch_valid_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   Scoreboard bench for vga_timing_gen on a reduced raster (15x10 ticks).
//   The reference model tracks the raster as a single linear tick index
//   within the frame plus a run mode; every output is derived from that
//   index arithmetically. Stimulus pushes the expected outputs per cycle,
//   a monitor pops and compares after each vgaclk rising edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int   CW = 6;
  localparam int   HACTIVE = 8, HFP = 2, HSYN = 3, HBP = 2;
  localparam int   VACTIVE = 6, VFP = 1, VSYN = 2, VBP = 1;
  localparam int   LEAD = 2;
  localparam logic HPOL = 1'b0, VPOL = 1'b1;
  localparam int   HMAX = HACTIVE + HFP + HSYN + HBP;
  localparam int   VMAX = VACTIVE + VFP + VSYN + VBP;
  localparam int   TOT  = HMAX * VMAX;

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          vgaclk = 1'b0;
  logic          reset = 1'b1, pix_en = 1'b0, run = 1'b0;
  logic          hsync, vsync, sync_b, blank_b, line_start, frame_start, active;
  logic [CW-1:0] x, y;
  logic [7:0]    frame_cnt;
`ifdef VGA_TIMING_FETCH_EN
  logic [CW-1:0] fetch_x, fetch_y;
  logic          fetch_valid;
`endif

  vga_timing_gen #(
    .CW(CW), .HACTIVE(HACTIVE), .HFP(HFP), .HSYN(HSYN), .HBP(HBP),
    .VACTIVE(VACTIVE), .VFP(VFP), .VSYN(VSYN), .VBP(VBP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .LEAD(LEAD)
  ) dut (
    .vgaclk(vgaclk), .reset(reset), .pix_en(pix_en), .run(run),
    .hsync(hsync), .vsync(vsync), .sync_b(sync_b), .blank_b(blank_b),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .frame_cnt(frame_cnt),
`ifdef VGA_TIMING_FETCH_EN
    .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_valid(fetch_valid),
`endif
    .active(active)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          hs, vs, sb, bb, ls, fs;
    logic [7:0]    fc;
    logic          act;
`ifdef VGA_TIMING_FETCH_EN
    logic [CW-1:0] fx;
    logic [CW-1:0] fy;
    logic          fv;
`endif
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // reference model state
  int         m_mode = M_IDLE;
  int         m_p    = 0;
  logic [7:0] m_fc   = '0;
  logic       m_ls   = 1'b0, m_fs = 1'b0;
  logic       rand_run;

  task automatic model_step(input logic r, input logic pe, input logic rn);
    logic wrapf;
    if (r) begin
      m_mode = M_IDLE; m_p = 0; m_fc = '0; m_ls = 1'b0; m_fs = 1'b0;
      return;
    end
    m_ls = 1'b0; m_fs = 1'b0;
    if (!pe) return;
    if (m_mode == M_IDLE) begin
      if (rn) begin
        m_mode = M_RUN; m_p = 0; m_ls = 1'b1; m_fs = 1'b1;
      end
      return;
    end
    wrapf = (m_p == TOT - 1);
    m_p   = (m_p + 1) % TOT;
    if (wrapf) m_fc = m_fc + 8'd1;
    if (m_mode == M_RUN) begin
      if (!rn) m_mode = wrapf ? M_IDLE : M_DRAIN;
    end else begin
      if (wrapf)   m_mode = M_IDLE;
      else if (rn) m_mode = M_RUN;
    end
    if (m_mode != M_IDLE && (m_p % HMAX) == 0) begin
      m_ls = 1'b1;
      m_fs = (m_p == 0);
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int   mx, my;
    logic on, ha, va;
    on = (m_mode != M_IDLE);
    mx = m_p % HMAX;
    my = m_p / HMAX;
    ha = on && mx >= HACTIVE + HFP && mx < HACTIVE + HFP + HSYN;
    va = on && my >= VACTIVE + VFP && my < VACTIVE + VFP + VSYN;
    o.x   = CW'(mx);
    o.y   = CW'(my);
    o.hs  = ha ? HPOL : ~HPOL;
    o.vs  = va ? VPOL : ~VPOL;
    o.sb  = !(ha || va);
    o.bb  = on && mx < HACTIVE && my < VACTIVE;
    o.ls  = m_ls;
    o.fs  = m_fs;
    o.fc  = m_fc;
    o.act = on;
`ifdef VGA_TIMING_FETCH_EN
    begin
      int fp;
      fp   = (m_p + LEAD) % TOT;
      o.fx = CW'(fp % HMAX);
      o.fy = CW'(fp / HMAX);
      o.fv = on && (fp % HMAX) < HACTIVE && (fp / HMAX) < VACTIVE;
    end
`endif
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = x; o.y = y; o.hs = hsync; o.vs = vsync; o.sb = sync_b; o.bb = blank_b;
    o.ls = line_start; o.fs = frame_start; o.fc = frame_cnt; o.act = active;
`ifdef VGA_TIMING_FETCH_EN
    o.fx = fetch_x; o.fy = fetch_y; o.fv = fetch_valid;
`endif
    return o;
  endfunction

  task automatic drive(input logic r, input logic pe, input logic rn);
    @(negedge vgaclk);
    reset = r; pix_en = pe; run = rn;
    model_step(r, pe, rn);
    exp_q.push_back(model_obs());
  endtask

  // Reset asserted mid-frame must show reset values before the next edge.
  task automatic reset_now_check();
    obs_t g, e;
    @(negedge vgaclk);
    reset = 1'b1; pix_en = 1'b1; run = 1'b1;
    model_step(1'b1, 1'b1, 1'b1);
    e = model_obs();
    exp_q.push_back(e);
    #1;
    g = dut_obs();
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL reset_async got x=%0d y=%0d act=%0b fc=%0d raw=%h want raw=%h",
               g.x, g.y, g.act, g.fc, g, e);
    end
  endtask

  // monitor
  initial begin
    obs_t e, g;
    forever begin
      @(posedge vgaclk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = dut_obs();
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL raster t=%0t got x=%0d y=%0d hs=%0b vs=%0b bb=%0b ls=%0b fs=%0b fc=%0d act=%0b raw=%h want x=%0d y=%0d hs=%0b vs=%0b bb=%0b ls=%0b fs=%0b fc=%0d act=%0b raw=%h",
                   $time, g.x, g.y, g.hs, g.vs, g.bb, g.ls, g.fs, g.fc, g.act, g,
                   e.x, e.y, e.hs, e.vs, e.bb, e.ls, e.fs, e.fc, e.act, e);
        end
      end
    end
  end

  // stimulus
  initial begin
    repeat (3) drive(1'b1, 1'b1, 1'b0);

    // continuous run for two full frames
    repeat (2 * TOT + 5) drive(1'b0, 1'b1, 1'b1);

    // pix_en at half rate
    for (int i = 0; i < 2 * TOT + 6; i++) drive(1'b0, (i % 2) == 0, 1'b1);

    // stop mid-frame: frame drains to the end, then idles
    for (int k = 0; k < 2 * TOT && m_p != 3 * HMAX + 5; k++) drive(1'b0, 1'b1, 1'b1);
    repeat (TOT + 10) drive(1'b0, 1'b1, 1'b0);

    // restart, stop, re-raise run while draining
    repeat (40) drive(1'b0, 1'b1, 1'b1);
    repeat (30) drive(1'b0, 1'b1, 1'b0);
    repeat (TOT) drive(1'b0, 1'b1, 1'b1);

    // asynchronous reset mid-frame, then restart from the origin
    repeat (57) drive(1'b0, 1'b1, 1'b1);
    reset_now_check();
    repeat (20) drive(1'b0, 1'b1, 1'b1);

    // run falls on exactly the frame-wrap tick
    for (int k = 0; k < 2 * TOT && m_p != TOT - 1; k++) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'b0);

    // DRAIN reaching the wrap with run idle at the wrap point
    repeat (30) drive(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2 * TOT && m_p != TOT - 3; k++) drive(1'b0, 1'b1, 1'b1);
    repeat (8) drive(1'b0, 1'b1, 1'b0);

    // random traffic
    rand_run = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) rand_run = ~rand_run;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, rand_run);
    end

    @(posedge vgaclk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
